onehot_decoder_stream: RTL and testbench

Parametrised, registered binary-to-one-hot decoder with a valid/ready handshake on both sides and an optional sweep mode that walks the active output from the selected index up to the top output. It generalises the fixed 2-to-4 enable decoder to SEL_W select bits and 2^SEL_W outputs. It sits between a command source issuing indices and downstream per-channel strobe logic, such as bank selects or channel grants.

---
 rtl/onehot_decoder_stream.sv | 90 +++++++++
 tb/tb_onehot_decoder_stream.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/onehot_decoder_stream.sv
// Registered binary-to-one-hot decoder with valid/ready on both sides; 1-cycle latency, in_ready = en & out_ready while holding.
// Optional sweep mode (walks the hot bit up to the MSB) is compiled in with `define ONEHOT_DECODER_SWEEP_EN.
module onehot_decoder_stream #(
  parameter int SEL_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   sweep,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [(1<<SEL_W)-1:0]  dec_out,
  output logic                   out_last,
  output logic                   busy
);

  localparam int OUT_W = 1 << SEL_W;

`ifdef ONEHOT_DECODER_SWEEP_EN
  typedef enum logic [1:0] {IDLE, HOLD, SWEEP} state_t;
`else
  typedef enum logic [1:0] {IDLE, HOLD} state_t;
  logic unused_sweep;
  assign unused_sweep = sweep;
`endif

  state_t           state_q, state_d;
  logic [OUT_W-1:0] dec_q, dec_d;
  logic [OUT_W-1:0] one_w;
  logic             in_acc, out_acc;

  assign one_w   = {{(OUT_W-1){1'b0}}, 1'b1};
  assign dec_out = dec_q;
  assign busy    = (state_q != IDLE);
  assign in_acc  = in_valid & in_ready;
  assign out_acc = out_valid & out_ready;

  always_comb begin
    out_valid = en & busy;
    in_ready  = 1'b0;
    case (state_q)
      IDLE:    in_ready = en;
      HOLD:    in_ready = en & out_ready;
      default: in_ready = 1'b0;
    endcase
`ifdef ONEHOT_DECODER_SWEEP_EN
    out_last = en & ((state_q == HOLD) | ((state_q == SWEEP) & dec_q[OUT_W-1]));
`else
    out_last = out_valid;
`endif
  end

  // en=0 masks both accepts, which is what freezes the state and sweep position.
  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    if (out_acc) begin
      state_d = IDLE;
      dec_d   = '0;
`ifdef ONEHOT_DECODER_SWEEP_EN
      if (state_q == SWEEP && !dec_q[OUT_W-1]) begin
        state_d = SWEEP;
        dec_d   = dec_q << 1;
      end
`endif
    end
    if (in_acc) begin
      dec_d = one_w << sel;
`ifdef ONEHOT_DECODER_SWEEP_EN
      state_d = sweep ? SWEEP : HOLD;
`else
      state_d = HOLD;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
    end
  end

endmodule

// File: tb/tb_onehot_decoder_stream.sv
// Bench for onehot_decoder_stream (SEL_W=2): directed requests feed an expected-beat queue, a monitor checks every presented beat.
module tb_onehot_decoder_stream;

  logic       clk = 1'b0;
  logic       rst, en, in_valid, in_ready, sweep, out_valid, out_ready, out_last, busy;
  logic [1:0] sel;
  logic [3:0] dec_out;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed { logic [3:0] dat; logic last; } beat_t;
  beat_t exp_q[$];

  onehot_decoder_stream #(.SEL_W(2)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .sweep(sweep), .out_valid(out_valid), .out_ready(out_ready),
    .dec_out(dec_out), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] d, input logic l);
    beat_t b;
    b.dat = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  // Monitor: every presented beat must match the queue head; pop on output accept.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {4'b0, dec_out}, 8'h00);
      end else begin
        check("beat_dat", {4'b0, dec_out}, {4'b0, exp_q[0].dat});
        check("beat_last", {7'b0, out_last}, {7'b0, exp_q[0].last});
        check("beat_onehot", {7'b0, $onehot(dec_out)}, 8'h01);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_idle(input string name);
    @(negedge clk);
    check({name, "_dec"}, {4'b0, dec_out}, 8'h00);
    check({name, "_vld"}, {7'b0, out_valid}, 8'h00);
    check({name, "_last"}, {7'b0, out_last}, 8'h00);
    check({name, "_busy"}, {7'b0, busy}, 8'h00);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; en = 1; in_valid = 0; out_ready = 0; sel = 0; sweep = 0;
    tick(); tick();
    check_idle("reset");
    rst = 0;
    @(negedge clk);
    check("reset_in_ready", {7'b0, in_ready}, 8'h01);
    tick();

    // Single decode with a 3-cycle stall.
    sel = 2; sweep = 0; in_valid = 1; out_ready = 0;
    push(4'b0100, 1'b1);
    tick();
    in_valid = 0;
    @(negedge clk);
    check("hold_busy", {7'b0, busy}, 8'h01);
    check("hold_in_ready_stall", {7'b0, in_ready}, 8'h00);
    tick(); tick(); tick();
    out_ready = 1;
    tick();
    check_idle("single_clear");

    // Back-to-back, out_ready tied high; in_ready must stay high.
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      sel = (i == 0) ? 2'd0 : (i == 1) ? 2'd3 : 2'd1;
      push((i == 0) ? 4'b0001 : (i == 1) ? 4'b1000 : 4'b0010, 1'b1);
      @(negedge clk);
      check("b2b_in_ready", {7'b0, in_ready}, 8'h01);
      tick();
    end
    in_valid = 0;
    tick();
    check_idle("b2b_end");

`ifdef ONEHOT_DECODER_SWEEP_EN
    // Sweep from sel=1: three beats, in_ready low throughout.
    sel = 1; sweep = 1; in_valid = 1;
    push(4'b0010, 1'b0); push(4'b0100, 1'b0); push(4'b1000, 1'b1);
    tick();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sweep_in_ready", {7'b0, in_ready}, 8'h00);
      tick();
    end
    check_idle("sweep_end");
    sel = 3; in_valid = 1;
    push(4'b1000, 1'b1);
    tick();
    in_valid = 0;
    tick();
    check_idle("sweep_top_end");
`else
    // Without sweep support the sweep bit is ignored: single beat.
    sel = 1; sweep = 1; in_valid = 1;
    push(4'b0010, 1'b1);
    tick();
    in_valid = 0;
    tick();
    check_idle("nosweep_end");
`endif

    // Pause for 3 cycles on a presented beat.
    sel = 1; sweep = 1; in_valid = 1;
`ifdef ONEHOT_DECODER_SWEEP_EN
    push(4'b0010, 1'b0); push(4'b0100, 1'b0); push(4'b1000, 1'b1);
    tick();
    in_valid = 0;
    tick();
`else
    push(4'b0010, 1'b1);
    tick();
    in_valid = 0;
`endif
    en = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("pause_vld", {7'b0, out_valid}, 8'h00);
      check("pause_in_ready", {7'b0, in_ready}, 8'h00);
      check("pause_last", {7'b0, out_last}, 8'h00);
      tick();
    end
    en = 1;
`ifdef ONEHOT_DECODER_SWEEP_EN
    tick(); tick();
`else
    tick();
`endif
    check_idle("pause_end");

    // Reset while a beat is pending drops it.
    sel = 1; in_valid = 1;
`ifdef ONEHOT_DECODER_SWEEP_EN
    sweep = 1;
    tick();
    in_valid = 0;
    tick();
`else
    sweep = 0; out_ready = 0;
    tick();
    in_valid = 0;
`endif
    rst = 1;
    exp_q.delete();
    tick();
    check_idle("midreset");
    rst = 0; out_ready = 1;
    sel = 2; sweep = 0; in_valid = 1;
    push(4'b0100, 1'b1);
    tick();
    in_valid = 0;
    tick();
    check_idle("post_reset_end");

    check("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
